// File: rtl/tl_execute_md.sv
// MIPS execute stage: forwarding muxes, ALU, branch-target adder, RegDst mux and an
// iterative multiply/divide unit with HI/LO. EX/MEM register and MD FSM advance on negedge.
module tl_execute_md #(
  parameter int LEN                  = 32,
  parameter int NB_ADDRESS_REGISTROS = 5,
  parameter int NB_ALU_CONTROL       = 4,
  parameter int NB_CTRL_WB           = 2,
  parameter int NB_CTRL_MEM          = 9,
  parameter int NB_CTRL_EX           = 8
) (
  input  logic                            i_clk,
  input  logic                            i_rst,
  input  logic                            i_valid,
  input  logic [LEN-1:0]                  i_adder_id,
  input  logic [LEN-1:0]                  i_dato1,
  input  logic [LEN-1:0]                  i_dato2,
  input  logic [LEN-1:0]                  i_sign_extend,
  input  logic [LEN-1:0]                  i_fwd_mem,
  input  logic [LEN-1:0]                  i_fwd_wb,
  input  logic [1:0]                      i_fwd_a_sel,
  input  logic [1:0]                      i_fwd_b_sel,
  input  logic [NB_CTRL_WB-1:0]           i_ctrl_wb,
  input  logic [NB_CTRL_MEM-1:0]          i_ctrl_mem,
  input  logic [NB_CTRL_EX-1:0]           i_ctrl_ex,
  input  logic                            i_md_start,
  input  logic [1:0]                      i_md_op,
  input  logic [1:0]                      i_md_read,
  input  logic [NB_ADDRESS_REGISTROS-1:0] i_rd,
  input  logic [NB_ADDRESS_REGISTROS-1:0] i_rt,
  input  logic [4:0]                      i_shamt,
  output logic                            o_stall,
  output logic                            o_md_busy,
  output logic                            o_valid,
  output logic                            o_alu_zero,
  output logic [NB_ADDRESS_REGISTROS-1:0] o_write_reg,
  output logic [NB_CTRL_WB-1:0]           o_ctrl_wb,
  output logic [NB_CTRL_MEM-1:0]          o_ctrl_mem,
  output logic [LEN-1:0]                  o_add_execute,
  output logic [LEN-1:0]                  o_alu_result,
  output logic [LEN-1:0]                  o_dato2
);

  localparam int NB_CNT = $clog2(LEN + 1);
  localparam int NB_SH  = $clog2(LEN);

  localparam logic [NB_ALU_CONTROL-1:0] ALU_AND  = 4'b0000;
  localparam logic [NB_ALU_CONTROL-1:0] ALU_OR   = 4'b0001;
  localparam logic [NB_ALU_CONTROL-1:0] ALU_ADD  = 4'b0010;
  localparam logic [NB_ALU_CONTROL-1:0] ALU_XOR  = 4'b0011;
  localparam logic [NB_ALU_CONTROL-1:0] ALU_SLL  = 4'b0100;
  localparam logic [NB_ALU_CONTROL-1:0] ALU_SRL  = 4'b0101;
  localparam logic [NB_ALU_CONTROL-1:0] ALU_SUB  = 4'b0110;
  localparam logic [NB_ALU_CONTROL-1:0] ALU_SLT  = 4'b0111;
  localparam logic [NB_ALU_CONTROL-1:0] ALU_SRA  = 4'b1000;
  localparam logic [NB_ALU_CONTROL-1:0] ALU_SLTU = 4'b1001;
  localparam logic [NB_ALU_CONTROL-1:0] ALU_LUI  = 4'b1010;
  localparam logic [NB_ALU_CONTROL-1:0] ALU_NOR  = 4'b1100;

  typedef enum logic [1:0] {MD_IDLE, MD_BUSY, MD_FIX} md_state_e;

  // ---------------- operand selection / ALU ----------------
  logic [LEN-1:0] fwd_a, fwd_b, alu_a, alu_b, alu_res, ex_result;
  logic [NB_ALU_CONTROL-1:0] alu_op;
  logic unused_ctrl_ex;

  assign unused_ctrl_ex = i_ctrl_ex[4];
  assign alu_op = i_ctrl_ex[NB_ALU_CONTROL-1:0];

  always_comb begin
    case (i_fwd_a_sel)
      2'b01:   fwd_a = i_fwd_mem;
      2'b10:   fwd_a = i_fwd_wb;
      default: fwd_a = i_dato1;
    endcase
    case (i_fwd_b_sel)
      2'b01:   fwd_b = i_fwd_mem;
      2'b10:   fwd_b = i_fwd_wb;
      default: fwd_b = i_dato2;
    endcase
  end

  assign alu_a = i_ctrl_ex[6] ? {{(LEN-5){1'b0}}, i_shamt} : fwd_a;
  assign alu_b = i_ctrl_ex[5] ? i_sign_extend : fwd_b;

  // Shifts move B by A, so shamt (ALUSrc1) and variable shifts share one path.
  always_comb begin
    alu_res = '0;
    case (alu_op)
      ALU_AND:  alu_res = alu_a & alu_b;
      ALU_OR:   alu_res = alu_a | alu_b;
      ALU_ADD:  alu_res = alu_a + alu_b;
      ALU_XOR:  alu_res = alu_a ^ alu_b;
      ALU_SLL:  alu_res = alu_b << alu_a[NB_SH-1:0];
      ALU_SRL:  alu_res = alu_b >> alu_a[NB_SH-1:0];
      ALU_SUB:  alu_res = alu_a - alu_b;
      ALU_SLT:  alu_res = {{(LEN-1){1'b0}}, $signed(alu_a) < $signed(alu_b)};
      ALU_SRA:  alu_res = $unsigned($signed(alu_b) >>> alu_a[NB_SH-1:0]);
      ALU_SLTU: alu_res = {{(LEN-1){1'b0}}, alu_a < alu_b};
      ALU_LUI:  alu_res = {alu_b[LEN/2-1:0], {(LEN/2){1'b0}}};
      ALU_NOR:  alu_res = ~(alu_a | alu_b);
      default:  alu_res = '0;
    endcase
  end

  // ---------------- multiply / divide ----------------
  md_state_e         state_q;
  logic [NB_CNT-1:0] cnt_q;
  logic [LEN-1:0]    acc_q, low_q, opb_q, hi_q, lo_q;
  logic              div_q, negq_q, negr_q, div0_q;

  logic           md_rd_lo, md_rd_hi, md_go, bubble;
  logic           sa, sb;
  logic [LEN-1:0] abs_a, abs_b;
  logic [LEN:0]   mul_sum, div_shift, div_diff;
  logic [2*LEN-1:0] prod_fix;
  logic [LEN-1:0] quo_fix, rem_fix;

  assign o_md_busy = (state_q != MD_IDLE);
  assign md_rd_lo  = (i_md_read == 2'b01);
  assign md_rd_hi  = (i_md_read == 2'b10);
  assign o_stall   = o_md_busy & i_valid & (i_md_start | md_rd_lo | md_rd_hi);
  assign md_go     = i_valid & i_md_start & ~o_md_busy;

  assign sa    = i_md_op[0] & fwd_a[LEN-1];
  assign sb    = i_md_op[0] & fwd_b[LEN-1];
  assign abs_a = sa ? -fwd_a : fwd_a;
  assign abs_b = sb ? -fwd_b : fwd_b;

  // acc_q: upper product / partial remainder; low_q: multiplier / dividend -> quotient.
  assign mul_sum   = {1'b0, acc_q} + (low_q[0] ? {1'b0, opb_q} : {(LEN+1){1'b0}});
  assign div_shift = {acc_q, low_q[LEN-1]};
  assign div_diff  = div_shift - {1'b0, opb_q};

  assign prod_fix = negq_q ? -{acc_q, low_q} : {acc_q, low_q};
  assign quo_fix  = div0_q ? {LEN{1'b1}} : (negq_q ? -low_q : low_q);
  assign rem_fix  = negr_q ? -acc_q : acc_q;

  always_ff @(negedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      low_q   <= '0;
      opb_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      div_q   <= 1'b0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      div0_q  <= 1'b0;
    end else begin
      case (state_q)
        MD_IDLE: if (md_go) begin
          state_q <= MD_BUSY;
          cnt_q   <= NB_CNT'(LEN);
          acc_q   <= '0;
          div_q   <= i_md_op[1];
          negq_q  <= sa ^ sb;
          negr_q  <= sa;
          div0_q  <= i_md_op[1] & (fwd_b == '0);
          low_q   <= i_md_op[1] ? abs_a : abs_b;
          opb_q   <= i_md_op[1] ? abs_b : abs_a;
        end
        MD_BUSY: begin
          if (div_q) begin
            // Restoring step: keep the subtraction only when it did not borrow.
            if (!div_diff[LEN]) begin
              acc_q <= div_diff[LEN-1:0];
              low_q <= {low_q[LEN-2:0], 1'b1};
            end else begin
              acc_q <= div_shift[LEN-1:0];
              low_q <= {low_q[LEN-2:0], 1'b0};
            end
          end else begin
            acc_q <= mul_sum[LEN:1];
            low_q <= {mul_sum[0], low_q[LEN-1:1]};
          end
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == NB_CNT'(1)) state_q <= MD_FIX;
        end
        MD_FIX: begin
          if (div_q) begin
            lo_q <= quo_fix;
            hi_q <= rem_fix;
          end else begin
            lo_q <= prod_fix[LEN-1:0];
            hi_q <= prod_fix[2*LEN-1:LEN];
          end
          state_q <= MD_IDLE;
        end
        default: state_q <= MD_IDLE;
      endcase
    end
  end

  // ---------------- EX/MEM register ----------------
  assign ex_result = md_rd_lo ? lo_q : (md_rd_hi ? hi_q : alu_res);
  // MD issue itself writes nothing, so it leaves as a bubble like a stalled slot.
  assign bubble    = o_stall | (i_valid & i_md_start);

  always_ff @(negedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      o_valid       <= 1'b0;
      o_alu_zero    <= 1'b0;
      o_write_reg   <= '0;
      o_ctrl_wb     <= '0;
      o_ctrl_mem    <= '0;
      o_add_execute <= '0;
      o_alu_result  <= '0;
      o_dato2       <= '0;
    end else if (bubble) begin
      o_valid       <= 1'b0;
      o_alu_zero    <= 1'b0;
      o_write_reg   <= '0;
      o_ctrl_wb     <= '0;
      o_ctrl_mem    <= '0;
      o_add_execute <= '0;
      o_alu_result  <= '0;
      o_dato2       <= '0;
    end else begin
      o_valid       <= i_valid;
      o_alu_zero    <= (alu_res == '0);
      o_write_reg   <= i_ctrl_ex[7] ? i_rd : i_rt;
      o_ctrl_wb     <= i_ctrl_wb;
      o_ctrl_mem    <= i_ctrl_mem;
      o_add_execute <= i_adder_id + i_sign_extend;
      o_alu_result  <= ex_result;
      o_dato2       <= fwd_b;
    end
  end

endmodule

// File: tb/tb_tl_execute_md.sv
// Directed bench for tl_execute_md: forwarding datapath, MD results, stalls and reset.
module tb_tl_execute_md;
  localparam int LEN = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            valid, md_start;
  logic [LEN-1:0]  adder_id, dato1, dato2, sext, fwd_mem, fwd_wb;
  logic [1:0]      fa_sel, fb_sel, md_op, md_read;
  logic [1:0]      ctrl_wb;
  logic [8:0]      ctrl_mem;
  logic [7:0]      ctrl_ex;
  logic [4:0]      rd, rt, shamt;
  logic            stall, busy, o_valid, zero;
  logic [4:0]      wreg;
  logic [1:0]      o_cwb;
  logic [8:0]      o_cmem;
  logic [LEN-1:0]  add_ex, alu_res, o_d2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  tl_execute_md dut (
    .i_clk(clk), .i_rst(rst), .i_valid(valid), .i_adder_id(adder_id),
    .i_dato1(dato1), .i_dato2(dato2), .i_sign_extend(sext),
    .i_fwd_mem(fwd_mem), .i_fwd_wb(fwd_wb), .i_fwd_a_sel(fa_sel), .i_fwd_b_sel(fb_sel),
    .i_ctrl_wb(ctrl_wb), .i_ctrl_mem(ctrl_mem), .i_ctrl_ex(ctrl_ex),
    .i_md_start(md_start), .i_md_op(md_op), .i_md_read(md_read),
    .i_rd(rd), .i_rt(rt), .i_shamt(shamt),
    .o_stall(stall), .o_md_busy(busy), .o_valid(o_valid), .o_alu_zero(zero),
    .o_write_reg(wreg), .o_ctrl_wb(o_cwb), .o_ctrl_mem(o_cmem),
    .o_add_execute(add_ex), .o_alu_result(alu_res), .o_dato2(o_d2)
  );

  task automatic chk(input string tag, input logic [LEN-1:0] obs, input logic [LEN-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Counts stalled negedges (bounded) and verifies each one loaded a bubble.
  task automatic wait_stall(input string tag, output int ns);
    logic bad;
    ns  = 0;
    bad = 1'b0;
    #1;
    while (stall && ns < 100) begin
      tick();
      ns++;
      if (o_valid !== 1'b0 || o_cwb !== 2'b00) bad = 1'b1;
    end
    chk({tag, "_bubble"}, 32'(bad), 32'd0);
  endtask

  task automatic md_go(input logic [1:0] op, input logic [LEN-1:0] a, input logic [LEN-1:0] b);
    valid = 1'b1; md_start = 1'b1; md_op = op; md_read = 2'b00;
    fa_sel = 2'b00; fb_sel = 2'b00; dato1 = a; dato2 = b;
    ctrl_ex = 8'h00; ctrl_wb = 2'b11;
    #1;
    chk("md_start_nostall", 32'(stall), 32'd0);
    tick();
    chk("md_issue_bubble", 32'(o_valid), 32'd0);
    chk("md_issue_busy", 32'(busy), 32'd1);
    md_start = 1'b0; valid = 1'b0;
  endtask

  task automatic mf(input string tag, input logic [1:0] sel, input int exp_ns,
                    input logic [LEN-1:0] exp_res);
    int ns;
    valid = 1'b1; md_read = sel; md_start = 1'b0; ctrl_wb = 2'b01;
    wait_stall(tag, ns);
    chk({tag, "_stalls"}, 32'(ns), 32'(exp_ns));
    tick();
    chk({tag, "_valid"}, 32'(o_valid), 32'd1);
    chk(tag, alu_res, exp_res);
    valid = 1'b0; md_read = 2'b00;
  endtask

  initial begin
    int ns;
    rst = 1'b0; valid = 1'b0; md_start = 1'b0; md_op = 2'b00; md_read = 2'b00;
    adder_id = '0; dato1 = '0; dato2 = '0; sext = '0; fwd_mem = '0; fwd_wb = '0;
    fa_sel = 2'b00; fb_sel = 2'b00; ctrl_wb = '0; ctrl_mem = '0; ctrl_ex = '0;
    rd = '0; rt = '0; shamt = '0;
    repeat (2) tick();
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_alu", alu_res, 32'd0);
    chk("rst_add", add_ex, 32'd0);
    @(posedge clk);
    rst = 1'b1;

    // ADD with rs from EX/MEM and rt from MEM/WB
    valid = 1'b1; dato1 = 32'd100; dato2 = 32'd200; fwd_mem = 32'd5; fwd_wb = 32'd7;
    fa_sel = 2'b01; fb_sel = 2'b10; ctrl_ex = 8'h02; rt = 5'd3; rd = 5'd9;
    adder_id = 32'h100; sext = 32'h10; ctrl_wb = 2'b10; ctrl_mem = 9'h1A5;
    tick();
    chk("add_result", alu_res, 32'd12);
    chk("add_dato2", o_d2, 32'd7);
    chk("add_wreg", 32'(wreg), 32'd3);
    chk("add_valid", 32'(o_valid), 32'd1);
    chk("add_zero", 32'(zero), 32'd0);
    chk("add_target", add_ex, 32'h110);
    chk("add_ctrl_wb", 32'(o_cwb), 32'd2);
    chk("add_ctrl_mem", 32'(o_cmem), 32'h1A5);

    // SUB with immediate, RegDst=rd, zero flag, branch target wrap
    fa_sel = 2'b00; dato1 = 32'd20; sext = 32'd20; adder_id = 32'hFFFF_FFF0; ctrl_ex = 8'hA6;
    tick();
    chk("sub_result", alu_res, 32'd0);
    chk("sub_zero", 32'(zero), 32'd1);
    chk("sub_wreg", 32'(wreg), 32'd9);
    chk("sub_target_wrap", add_ex, 32'd4);
    chk("sub_dato2_preimm", o_d2, 32'd7);

    // SLL by shamt, operand B from dato2 via sel 11
    ctrl_ex = 8'h44; shamt = 5'd4; fb_sel = 2'b11; dato2 = 32'hF3;
    tick();
    chk("sll_result", alu_res, 32'hF30);
    chk("sll_dato2", o_d2, 32'hF3);
    chk("sll_wreg", 32'(wreg), 32'd3);

    valid = 1'b0;
    tick();
    chk("bubble_valid", 32'(o_valid), 32'd0);

    md_go(2'b01, -32'sd7, 32'd3);
    mf("mult_lo", 2'b01, 33, 32'hFFFF_FFEB);
    mf("mult_hi", 2'b10, 0, 32'hFFFF_FFFF);

    md_go(2'b11, -32'sd7, 32'd2);
    mf("div_lo", 2'b01, 33, 32'hFFFF_FFFD);
    mf("div_hi", 2'b10, 0, 32'hFFFF_FFFF);

    md_go(2'b10, 32'd7, 32'd2);
    mf("divu_lo", 2'b01, 33, 32'd3);
    mf("divu_hi", 2'b10, 0, 32'd1);

    md_go(2'b10, 32'd9, 32'd0);
    mf("div0_lo", 2'b01, 33, 32'hFFFF_FFFF);
    mf("div0_hi", 2'b10, 0, 32'd9);

    // Reset mid-operation: HI/LO (currently 9 / all ones) and FSM cleared at once
    md_go(2'b00, 32'd3, 32'd5);
    repeat (3) tick();
    chk("pre_rst_busy", 32'(busy), 32'd1);
    #1 rst = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_valid", 32'(o_valid), 32'd0);
    chk("mid_rst_add", add_ex, 32'd0);
    @(posedge clk);
    rst = 1'b1;
    mf("rst_lo", 2'b01, 0, 32'd0);
    mf("rst_hi", 2'b10, 0, 32'd0);

    // Back-to-back MULTU: second waits for the first, result is the second's alone
    md_go(2'b00, 32'd6, 32'd7);
    valid = 1'b1; md_start = 1'b1; md_op = 2'b00; dato1 = 32'h1_0000; dato2 = 32'h1_0000;
    wait_stall("b2b", ns);
    chk("b2b_stalls", 32'(ns), 32'd33);
    tick();
    chk("b2b_restart_busy", 32'(busy), 32'd1);
    md_start = 1'b0; valid = 1'b0;
    mf("b2b_lo", 2'b01, 33, 32'd0);
    mf("b2b_hi", 2'b10, 0, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
